pc_sequencer: RTL and testbench

Control block that drives the program counter's PC-source select and stall inputs. Each cycle it picks the next-PC source from exception, interrupt, branch, jump, jr and load-use hazard requests. It generates pipeline flush and stall strobes and captures the exception return address (EPC). It sits between the ID/EX hazard and decode logic and the program counter in the 5-stage MIPS pipeline.

---
 rtl/pc_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC source selection, stall/flush strobes and EPC capture
// for a 5-stage MIPS pipeline.
//
// Ports:
//   i_clk, i_reset (sync, active low)
//   i_irq, i_illegal_op, i_load_use, i_branch_ex, i_branch_taken,
//   i_jump_id, i_jr_id, i_pc_id[31:0], i_kernel
//   o_pcsrc[2:0] : 000 seq, 001 branch, 010 jump, 011 jr, 100 irq, 101 exc
//   o_pc_stall, o_id_stall, o_flush_if, o_flush_id (combinational)
//   o_epc_we, o_epc[31:0] (registered)
//
// Optional feature: define PCSEQ_IRQ_HOLDOFF_EN to block irq for
// HOLDOFF_CYCLES cycles after each kernel 1->0 transition.
module pc_sequencer #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned TRAP_MASK_CYCLES  = 3
`ifdef PCSEQ_IRQ_HOLDOFF_EN
  , parameter int unsigned HOLDOFF_CYCLES  = 4
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_irq,
  input  logic        i_illegal_op,
  input  logic        i_load_use,
  input  logic        i_branch_ex,
  input  logic        i_branch_taken,
  input  logic        i_jump_id,
  input  logic        i_jr_id,
  input  logic [31:0] i_pc_id,
  input  logic        i_kernel,
  output logic [2:0]  o_pcsrc,
  output logic        o_pc_stall,
  output logic        o_id_stall,
  output logic        o_flush_if,
  output logic        o_flush_id,
  output logic        o_epc_we,
  output logic [31:0] o_epc
);

  localparam int unsigned LCNT_W = 3;
  localparam int unsigned MCNT_W = 4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LSTALL   = 2'd1,
    S_TRAPMASK = 2'd2
  } state_t;

  state_t              r_state;
  logic [LCNT_W-1:0]   r_lcnt;     // extra bubble cycles still owed
  logic [MCNT_W-1:0]   r_mcnt;     // trap-mask cycles still to run
  logic                r_irq_pend;

  state_t              w_state_nxt;
  logic [LCNT_W-1:0]   w_lcnt_nxt;
  logic [MCNT_W-1:0]   w_mcnt_nxt;
  logic                w_pend_nxt;
  logic                w_masked;
  logic                w_stalling;
  logic                w_take_br;
  logic                w_holdoff;
  logic                w_irq_ok;
  logic                w_irq_eff;
  logic                w_trap_ill;
  logic                w_trap_irq;
  logic                w_trap;
  logic                w_set_pend;
  logic                w_start_ls;

`ifdef PCSEQ_IRQ_HOLDOFF_EN
  localparam int unsigned HCNT_W = 8;
  logic              r_kernel_q;
  logic [HCNT_W-1:0] r_hcnt;
  logic              w_kfall;

  // The falling-edge cycle itself is already blocked, then HOLDOFF_CYCLES-1 more.
  assign w_kfall   = r_kernel_q & ~i_kernel;
  assign w_holdoff = w_kfall | (r_hcnt != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_kernel_q <= 1'b0;
      r_hcnt     <= '0;
    end else begin
      r_kernel_q <= i_kernel;
      if (w_kfall)
        r_hcnt <= HCNT_W'(HOLDOFF_CYCLES - 1);
      else if (r_hcnt != '0)
        r_hcnt <= r_hcnt - HCNT_W'(1);
    end
  end
`else
  assign w_holdoff = 1'b0;
`endif

  assign w_masked   = (r_state == S_TRAPMASK);
  assign w_stalling = (r_lcnt != '0);
  assign w_take_br  = i_branch_ex & i_branch_taken;
  assign w_irq_ok   = ~i_kernel & ~w_holdoff;
  assign w_irq_eff  = (i_irq | r_irq_pend) & w_irq_ok;
  assign w_trap     = w_trap_ill | w_trap_irq;

  // Priority resolution for PC source and strobes.
  always_comb begin
    o_pcsrc    = 3'b000;
    o_pc_stall = 1'b0;
    o_id_stall = 1'b0;
    o_flush_if = 1'b0;
    o_flush_id = 1'b0;
    w_trap_ill = 1'b0;
    w_trap_irq = 1'b0;
    w_set_pend = 1'b0;
    w_start_ls = 1'b0;
    if (i_reset) begin
      if (!w_masked && i_illegal_op) begin
        o_pcsrc    = 3'b101;
        o_flush_if = 1'b1;
        o_flush_id = 1'b1;
        w_trap_ill = 1'b1;
      end else if (!w_masked && w_irq_eff && !w_take_br) begin
        o_pcsrc    = 3'b100;
        o_flush_if = 1'b1;
        o_flush_id = 1'b1;
        w_trap_irq = 1'b1;
      end else if (w_stalling) begin
        o_pc_stall = 1'b1;
        o_id_stall = 1'b1;
        o_flush_id = 1'b1;
      end else if (w_take_br) begin
        o_pcsrc    = 3'b001;
        o_flush_if = 1'b1;
        o_flush_id = 1'b1;
        // irq losing to the branch is remembered, unless trap-masked
        w_set_pend = i_irq & w_irq_ok & ~w_masked;
      end else if (i_jr_id) begin
        o_pcsrc    = 3'b011;
        o_flush_if = 1'b1;
      end else if (i_jump_id) begin
        o_pcsrc    = 3'b010;
        o_flush_if = 1'b1;
      end else if (i_load_use) begin
        o_pc_stall = 1'b1;
        o_id_stall = 1'b1;
        o_flush_id = 1'b1;
        w_start_ls = 1'b1;
      end
    end
  end

  // Next-state values for counters, pending flag and state.
  always_comb begin
    w_mcnt_nxt = '0;
    w_lcnt_nxt = '0;
    w_pend_nxt = r_irq_pend;
    if (w_trap)
      w_mcnt_nxt = MCNT_W'(TRAP_MASK_CYCLES);
    else if (r_mcnt != '0)
      w_mcnt_nxt = r_mcnt - MCNT_W'(1);
    if (!w_trap) begin
      if (w_stalling)
        w_lcnt_nxt = r_lcnt - LCNT_W'(1);
      else if (w_start_ls)
        w_lcnt_nxt = LCNT_W'(LOAD_STALL_CYCLES - 1);
    end
    if (i_kernel || w_trap_irq)
      w_pend_nxt = 1'b0;
    else if (w_set_pend)
      w_pend_nxt = 1'b1;
    if (w_mcnt_nxt != '0)
      w_state_nxt = S_TRAPMASK;
    else if (w_lcnt_nxt != '0)
      w_state_nxt = S_LSTALL;
    else
      w_state_nxt = S_RUN;
  end

  // State, counters and EPC registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_RUN;
      r_lcnt     <= '0;
      r_mcnt     <= '0;
      r_irq_pend <= 1'b0;
      o_epc_we   <= 1'b0;
      o_epc      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_mcnt     <= w_mcnt_nxt;
      r_irq_pend <= w_pend_nxt;
      o_epc_we   <= w_trap;
      if (w_trap_ill)
        o_epc <= i_pc_id + 32'd4;
      else if (w_trap_irq)
        o_epc <= i_pc_id;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam int LSC = 2;
  localparam int TMC = 3;
  localparam int HOC = 4;

  logic        clk = 1'b0;
  logic        rst, irq, ill, lu, bex, btk, jmp, jr, kern;
  logic [31:0] pc;
  logic [2:0]  o_pcsrc;
  logic        o_pc_stall, o_id_stall, o_flush_if, o_flush_id, o_epc_we;
  logic [31:0] o_epc;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.LOAD_STALL_CYCLES(LSC), .TRAP_MASK_CYCLES(TMC)) dut (
    .i_clk(clk), .i_reset(rst), .i_irq(irq), .i_illegal_op(ill),
    .i_load_use(lu), .i_branch_ex(bex), .i_branch_taken(btk),
    .i_jump_id(jmp), .i_jr_id(jr), .i_pc_id(pc), .i_kernel(kern),
    .o_pcsrc(o_pcsrc), .o_pc_stall(o_pc_stall), .o_id_stall(o_id_stall),
    .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
    .o_epc_we(o_epc_we), .o_epc(o_epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: remaining mask cycles, owed bubbles, pending irq, holdoff.
  int          m_mask = 0, m_stall = 0, m_hold = 0;
  bit          m_pend = 0, m_kprev = 0, m_we = 0;
  logic [31:0] m_epc = 0;
  int          n_mask, n_stall, n_hold;
  bit          n_pend, n_kprev, n_we;
  logic [31:0] n_epc;
  bit          started = 0;

  always @(negedge clk) begin
    logic [2:0] e_src;
    bit e_st, e_fi, e_fd, hold_blk, irq_ok, br, trap;
    e_src = 3'd0; e_st = 0; e_fi = 0; e_fd = 0; trap = 0;
    if (!rst) begin
      n_mask = 0; n_stall = 0; n_hold = 0; n_pend = 0; n_kprev = 0;
      n_we = 0; n_epc = 32'd0;
    end else begin
      hold_blk = 0;
      n_hold   = 0;
`ifdef PCSEQ_IRQ_HOLDOFF_EN
      hold_blk = (m_kprev && !kern) || (m_hold > 0);
      n_hold   = (m_kprev && !kern) ? HOC - 1 : (m_hold > 0 ? m_hold - 1 : 0);
`endif
      irq_ok  = !kern && !hold_blk;
      br      = bex && btk;
      n_pend  = m_pend;
      n_mask  = (m_mask > 0) ? m_mask - 1 : 0;
      n_stall = 0;
      n_epc   = m_epc;
      n_kprev = kern;
      if (m_mask == 0 && ill) begin
        e_src = 3'd5; e_fi = 1; e_fd = 1; n_epc = pc + 32'd4; trap = 1;
      end else if (m_mask == 0 && (irq || m_pend) && irq_ok && !br) begin
        e_src = 3'd4; e_fi = 1; e_fd = 1; n_epc = pc; trap = 1; n_pend = 0;
      end else if (m_stall > 0) begin
        e_st = 1; e_fd = 1; n_stall = m_stall - 1;
      end else if (br) begin
        e_src = 3'd1; e_fi = 1; e_fd = 1;
        if (irq && irq_ok && m_mask == 0) n_pend = 1;
      end else if (jr) begin
        e_src = 3'd3; e_fi = 1;
      end else if (jmp) begin
        e_src = 3'd2; e_fi = 1;
      end else if (lu) begin
        e_st = 1; e_fd = 1; n_stall = LSC - 1;
      end
      if (trap) n_mask = TMC;
      n_we = trap;
      if (kern) n_pend = 0;
    end
    if (started) begin
      chk("m_pcsrc", 32'(o_pcsrc), 32'(e_src));
      chk("m_pc_stall", 32'(o_pc_stall), 32'(e_st));
      chk("m_id_stall", 32'(o_id_stall), 32'(e_st));
      chk("m_flush_if", 32'(o_flush_if), 32'(e_fi));
      chk("m_flush_id", 32'(o_flush_id), 32'(e_fd));
      chk("m_epc_we", 32'(o_epc_we), 32'(m_we));
      chk("m_epc", o_epc, m_epc);
    end
  end

  always @(posedge clk) begin
    if (started) begin
      m_mask = n_mask; m_stall = n_stall; m_hold = n_hold; m_pend = n_pend;
      m_kprev = n_kprev; m_we = n_we; m_epc = n_epc;
    end
    started = 1;
  end

  task automatic drive(input logic r, input logic q, input logic il, input logic l,
                       input logic be, input logic bt, input logic jm, input logic j,
                       input logic [31:0] p, input logic k);
    @(posedge clk); #1;
    rst = r; irq = q; ill = il; lu = l; bex = be; btk = bt; jmp = jm; jr = j;
    pc = p; kern = k;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 0);
  endtask

  initial begin
    rst = 0; irq = 1; ill = 1; lu = 0; bex = 0; btk = 0; jmp = 0; jr = 0;
    pc = 32'h0; kern = 0;
    // reset with irq and illegal_op asserted
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0100, 0);
      chk("rst_pcsrc", 32'(o_pcsrc), 32'd0);
      chk("rst_strobes", 32'({o_pc_stall, o_id_stall, o_flush_if, o_flush_id, o_epc_we}), 32'd0);
      chk("rst_epc", o_epc, 32'd0);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_1000, 0);
    chk("irq_first", 32'(o_pcsrc), 32'd4);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1004, 0);
    chk("irq_epc", o_epc, 32'h0000_1000);
    chk("irq_we", 32'(o_epc_we), 32'd1);
    idle(4);
    // load-use: two bubble cycles
    drive(1, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0200, 0);
    chk("lu_c1", 32'({o_pc_stall, o_id_stall, o_flush_id}), 32'd7);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0200, 0);
    chk("lu_c2", 32'({o_pc_stall, o_id_stall, o_flush_id}), 32'd7);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0204, 0);
    chk("lu_done", 32'({o_pcsrc, o_pc_stall, o_id_stall}), 32'd0);
    // branch beats jump and load-use
    drive(1, 0, 0, 1, 1, 1, 1, 0, 32'h0000_0300, 0);
    chk("br_pcsrc", 32'(o_pcsrc), 32'd1);
    chk("br_flush", 32'({o_flush_if, o_flush_id, o_pc_stall}), 32'd6);
    // branch with irq: irq deferred one cycle
    drive(1, 1, 0, 0, 1, 1, 0, 0, 32'h0000_2000, 0);
    chk("brirq_c1", 32'(o_pcsrc), 32'd1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_2004, 0);
    chk("brirq_c2", 32'(o_pcsrc), 32'd4);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_2008, 0);
    chk("brirq_epc", o_epc, 32'h0000_2004);
    chk("brirq_we", 32'(o_epc_we), 32'd1);
    idle(4);
    // illegal op, then irq masked for three cycles
    drive(1, 0, 1, 0, 0, 0, 0, 0, 32'h0040_0010, 0);
    chk("ill_pcsrc", 32'(o_pcsrc), 32'd5);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0014, 0);
    chk("ill_epc", o_epc, 32'h0040_0014);
    chk("ill_we", 32'(o_epc_we), 32'd1);
    chk("mask_1", 32'(o_pcsrc), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0018, 0);
    chk("mask_2", 32'(o_pcsrc), 32'd0);
    chk("mask_we_once", 32'(o_epc_we), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_001C, 0);
    chk("mask_3", 32'(o_pcsrc), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0020, 0);
    chk("mask_end", 32'(o_pcsrc), 32'd4);
    idle(5);
    // epc wrap-around
    drive(1, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);
    chk("wrap_epc", o_epc, 32'h0000_0000);
    idle(4);
    // kernel exit with irq held high
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 1);
    chk("kern_ign", 32'(o_pcsrc), 32'd0);
`ifdef PCSEQ_IRQ_HOLDOFF_EN
    for (int i = 0; i < HOC; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0400, 0);
      chk("hold_blk", 32'(o_pcsrc), 32'd0);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0404, 0);
    chk("hold_take", 32'(o_pcsrc), 32'd4);
`else
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0400, 0);
    chk("kexit_take", 32'(o_pcsrc), 32'd4);
`endif
    idle(5);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, q, il, l, be, bt, jm, j, k;
      logic [31:0] p;
      r  = ($urandom_range(0, 299) != 0);
      q  = ($urandom_range(0, 7) == 0);
      il = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 5) == 0);
      be = (m_stall == 0) && ($urandom_range(0, 3) == 0);
      bt = $urandom_range(0, 1) == 1;
      jm = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 7) == 0);
      k  = ($urandom_range(0, 39) == 0) ? ~kern : kern;
      p  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      drive(r, q, il, l, be, bt, jm, j, p, k);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
